// File: rtl/aq_sigcap_seq.sv
// ---------------------------------------------------------------------------
// aq_sigcap_seq
// Capture sequencer for the signal-capture buffer. Owns write port A of the
// capture RAM. After ARM it writes a pre-trigger ring, evaluates a
// mask/value (level or rising-edge) trigger or FORCE_TRIG, writes POST_COUNT
// further samples, then stops and reports the trigger and oldest-sample
// addresses.
//
// Ports
//   CAP_CLK               capture clock (sole clock)
//   RST                   synchronous active-high reset
//   CAP_DATA              sample input, taken every rising edge
//   ARM / ABORT           1-cycle command pulses (ABORT wins)
//   FORCE_TRIG            unconditional trigger, honoured only while waiting
//   TRIG_MASK/TRIG_VALUE  trigger compare (mask bit 1 = compare)
//   TRIG_EDGE             0 = level match, 1 = rising edge of match
//   PRE_COUNT/POST_COUNT  samples before trigger eligibility / after trigger
//   A_ADDR/A_WE/A_DO      RAM port A write interface (registered)
//   BUSY/TRIGGERED/DONE   status
//   TRIG_ADDR/START_ADDR  trigger sample address / oldest valid sample
// ---------------------------------------------------------------------------
module aq_sigcap_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CAP_CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] CAP_DATA,
    input  logic              ARM,
    input  logic              ABORT,
    input  logic              FORCE_TRIG,
    input  logic [DATA_W-1:0] TRIG_MASK,
    input  logic [DATA_W-1:0] TRIG_VALUE,
    input  logic              TRIG_EDGE,
    input  logic [ADDR_W-1:0] PRE_COUNT,
    input  logic [ADDR_W-1:0] POST_COUNT,
    output logic [ADDR_W-1:0] A_ADDR,
    output logic [3:0]        A_WE,
    output logic [DATA_W-1:0] A_DO,
    output logic              BUSY,
    output logic              TRIGGERED,
    output logic              DONE,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic [ADDR_W-1:0] START_ADDR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]   cnt_inc;
    logic                match_d_reg;
    logic [ADDR_W-1:0]   a_addr_reg;
    logic [3:0]          a_we_reg;
    logic [DATA_W-1:0]   a_do_reg;
    logic                busy_reg;
    logic                triggered_reg;
    logic                done_reg;
    logic [ADDR_W-1:0]   trig_addr_reg;
    logic [ADDR_W-1:0]   start_addr_reg;

    logic                match;
    logic                hit;
    logic                capturing;
    logic                arm_take;
    logic                trig_take;

    always_comb begin
        match      = ((CAP_DATA ^ TRIG_VALUE) & TRIG_MASK) == '0;
        hit        = TRIG_EDGE ? (match & ~match_d_reg) : match;
        cnt_inc    = cnt_reg + 1'b1;
        capturing  = (state_reg == ST_PRE) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_POST);
        state_next = state_reg;
        arm_take   = 1'b0;
        trig_take  = 1'b0;
        if (ABORT) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (ARM) begin
                        arm_take   = 1'b1;
                        state_next = (PRE_COUNT != '0) ? ST_PRE : ST_WAIT;
                    end
                end
                ST_PRE: begin
                    // The edge that writes sample PRE_COUNT is the last PRE edge;
                    // triggers are not evaluated on it.
                    if (cnt_inc == PRE_COUNT) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hit || FORCE_TRIG) begin
                        trig_take  = 1'b1;
                        state_next = (POST_COUNT != '0) ? ST_POST : ST_DONE;
                    end
                end
                ST_POST: begin
                    if (cnt_inc == POST_COUNT) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CAP_CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            match_d_reg    <= 1'b0;
            a_addr_reg     <= '0;
            a_we_reg       <= 4'h0;
            a_do_reg       <= '0;
            busy_reg       <= 1'b0;
            triggered_reg  <= 1'b0;
            done_reg       <= 1'b0;
            trig_addr_reg  <= '0;
            start_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Status flags mirror the state being entered so they stay registered.
            busy_reg  <= (state_next == ST_PRE) || (state_next == ST_WAIT) ||
                         (state_next == ST_POST);
            done_reg  <= (state_next == ST_DONE);
            a_we_reg  <= (capturing && !ABORT) ? 4'hF : 4'h0;
            if (ABORT) begin
                triggered_reg <= 1'b0;
            end else begin
                if (arm_take) begin
                    wr_ptr_reg    <= '0;
                    cnt_reg       <= '0;
                    triggered_reg <= 1'b0;
                    match_d_reg   <= 1'b0;
                end
                if (capturing) begin
                    a_addr_reg  <= wr_ptr_reg;
                    a_do_reg    <= CAP_DATA;
                    wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                    match_d_reg <= match;
                    cnt_reg     <= cnt_inc;
                end
                if (trig_take) begin
                    trig_addr_reg  <= wr_ptr_reg;
                    start_addr_reg <= wr_ptr_reg - PRE_COUNT;
                    triggered_reg  <= 1'b1;
                    cnt_reg        <= '0;
                end
            end
        end
    end

    assign A_ADDR     = a_addr_reg;
    assign A_WE       = a_we_reg;
    assign A_DO       = a_do_reg;
    assign BUSY       = busy_reg;
    assign TRIGGERED  = triggered_reg;
    assign DONE       = done_reg;
    assign TRIG_ADDR  = trig_addr_reg;
    assign START_ADDR = start_addr_reg;

endmodule
